// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order instruction reads, queues returned words and
// hands them to decode with their PC. Redirects flush the queue and discard
// any responses still owed by memory.
module instruction_fetch_unit #(
  parameter int unsigned  N        = 32,
  parameter int unsigned  DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [N-1:0] redirect_addr,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [N-1:0] mem_req_addr,
  input  logic         mem_resp_valid,
  input  logic [N-1:0] mem_resp_data,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [N-1:0] inst_data,
  output logic [N-1:0] inst_pc,
  output logic [N-1:0] inst_pc4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [N-1:0]     fpc;
  logic [N-1:0]     pc_q   [DEPTH];
  logic [N-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill;
  logic [CW-1:0]    alloc_cnt;
  logic [CW-1:0]    filled_cnt;
  logic [CW-1:0]    drop_cnt;

  logic             issue;
  logic             pop;
  logic             resp_keep;
  logic             resp_drop;
  logic [CW:0]      credit_used;
  logic [CW:0]      drop_redirect;
  logic [N-1:0]     redirect_target;

  // Issue credit, head presentation and per-cycle event decode.
  always_comb begin
    credit_used     = (CW+1)'(alloc_cnt) + (CW+1)'(drop_cnt);
    mem_req_valid   = !redirect && (credit_used < (CW+1)'(DEPTH));
    mem_req_addr    = fpc;
    inst_valid      = !redirect && (alloc_cnt != '0) && filled_q[head];
    inst_data       = data_q[head];
    inst_pc         = pc_q[head];
    inst_pc4        = pc_q[head] + N'(4);
    issue           = mem_req_valid && mem_req_ready;
    pop             = inst_valid && inst_ready;
    resp_drop       = mem_resp_valid && (drop_cnt != '0);
    resp_keep       = mem_resp_valid && (drop_cnt == '0);
    // Every issued-but-unanswered request becomes stale; a response arriving
    // in the redirect cycle is one of them and is consumed right here.
    drop_redirect   = (CW+1)'(alloc_cnt) - (CW+1)'(filled_cnt)
                    + (CW+1)'(drop_cnt) - (CW+1)'(mem_resp_valid);
    redirect_target = redirect_addr & ~N'(3);
  end

  // Fetch address, queue storage, pointers and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fpc        <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
      drop_cnt   <= '0;
      filled_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[PW'(i)]   <= '0;
        data_q[PW'(i)] <= '0;
      end
    end else if (redirect) begin
      fpc        <= redirect_target;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
      filled_q   <= '0;
      drop_cnt   <= CW'(drop_redirect);
    end else begin
      if (issue) begin
        pc_q[tail]     <= fpc;
        filled_q[tail] <= 1'b0;
        tail           <= tail + PW'(1);
        fpc            <= fpc + N'(4);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (resp_keep) begin
        data_q[fill]   <= mem_resp_data;
        filled_q[fill] <= 1'b1;
        fill           <= fill + PW'(1);
      end
      if (pop) begin
        filled_q[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      alloc_cnt  <= alloc_cnt + CW'(issue) - CW'(pop);
      filled_cnt <= filled_cnt + CW'(resp_keep) - CW'(pop);
    end
  end

endmodule
